// File: rtl/fetch_aligner_pkg.sv
// fetch_aligner_pkg
//  Shared constants and types for the fetch aligner and its halfword queue.
//  ALIGN_Q_DEPTH : halfword queue depth (4)
//  ALIGN_CNT_W   : width of the queue occupancy counter (holds 0..4)
//  RVC_OPC_FULL  : low two opcode bits that mark a full 32-bit instruction
package fetch_aligner_pkg;

    localparam int         ALIGN_Q_DEPTH = 4;
    localparam int         ALIGN_CNT_W   = 3;
    localparam logic [1:0] RVC_OPC_FULL  = 2'b11;

    typedef logic [15:0]            halfword_t;
    typedef logic [ALIGN_CNT_W-1:0] count_t;

    // A halfword whose low opcode bits are 2'b11 starts a 32-bit instruction.
    function automatic logic is_full_inst(input halfword_t hw);
        return hw[1:0] == RVC_OPC_FULL;
    endfunction

endpackage

// File: rtl/fetch_aligner_halfword_queue.sv
// fetch_aligner_halfword_queue
//  4-entry shift queue of 16-bit halfwords. Entry 0 is always the head, so the
//  consumer reads head_lo/head_hi directly from registers.
//  Each cycle it pops 0/1/2 halfwords from the head, then appends 0/1/2
//  halfwords behind what is left. flush empties the queue and wins over both.
// Ports
//  clk, rst_n        clock, async active-low reset
//  flush             discard all entries
//  push_cnt          number of halfwords to append (0..2)
//  push_lo, push_hi  halfwords to append (push_lo first)
//  pop_cnt           number of halfwords to remove from the head (0..2)
//  head_lo, head_hi  entries 0 and 1
//  count             current occupancy (0..4)
module fetch_aligner_halfword_queue
    import fetch_aligner_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic [1:0] push_cnt,
    input  halfword_t push_lo,
    input  halfword_t push_hi,
    input  logic [1:0] pop_cnt,
    output halfword_t head_lo,
    output halfword_t head_hi,
    output count_t    count
);

    halfword_t entry_reg  [ALIGN_Q_DEPTH];
    halfword_t entry_next [ALIGN_Q_DEPTH];
    count_t    count_reg;
    count_t    mid_cnt;
    count_t    count_next;

    // Occupancy after the pop; the push lands starting at this slot.
    assign mid_cnt    = count_reg - count_t'(pop_cnt);
    assign count_next = flush ? '0 : mid_cnt + count_t'(push_cnt);

    genvar gi;
    generate
        for (gi = 0; gi < ALIGN_Q_DEPTH; gi++) begin : g_entry
            halfword_t shifted;

            // Entry gi after the pop takes entry gi+pop_cnt; slots past the
            // end shift in zero.
            if (gi + 2 < ALIGN_Q_DEPTH) begin : g_s2
                assign shifted = (pop_cnt == 2'd2) ? entry_reg[gi+2] :
                                 (pop_cnt == 2'd1) ? entry_reg[gi+1] : entry_reg[gi];
            end else if (gi + 1 < ALIGN_Q_DEPTH) begin : g_s1
                assign shifted = (pop_cnt == 2'd1) ? entry_reg[gi+1] :
                                 (pop_cnt == 2'd0) ? entry_reg[gi]   : '0;
            end else begin : g_s0
                assign shifted = (pop_cnt == 2'd0) ? entry_reg[gi] : '0;
            end

            assign entry_next[gi] =
                ((push_cnt != 2'd0) && (mid_cnt == count_t'(gi)))                   ? push_lo :
                ((push_cnt == 2'd2) && ((mid_cnt + count_t'(1)) == count_t'(gi)))   ? push_hi :
                                                                                      shifted;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            for (int i = 0; i < ALIGN_Q_DEPTH; i++) entry_reg[i] <= '0;
        end else if (flush) begin
            count_reg <= '0;
            for (int i = 0; i < ALIGN_Q_DEPTH; i++) entry_reg[i] <= '0;
        end else begin
            count_reg <= count_next;
            for (int i = 0; i < ALIGN_Q_DEPTH; i++) entry_reg[i] <= entry_next[i];
        end
    end

    assign head_lo = entry_reg[0];
    assign head_hi = entry_reg[1];
    assign count   = count_reg;

endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner
//  Splits 32-bit word-aligned fetch data into individual instructions for the
//  decoders. Buffers leftover halfwords, joins 32-bit instructions that
//  straddle fetch words and tags compressed (RVC) instructions.
//  Outputs come only from registered queue state: a word pushed in cycle N is
//  visible on inst_* in cycle N+1.
// Configuration macro: ALIGNER_RVC_EN
//  defined   : RVC support; inst_misaligned_o tied 0.
//  undefined : every instruction is 32-bit, inst_compressed_o tied 0. A fetch
//              with fetch_pc_i[1]=1 produces one instruction tagged
//              inst_misaligned_o=1 (inst_o=0, pc=fetch_pc_i); its halfword is
//              dropped.
// Ports
//  clk_i, rst_ni       clock, async active-low reset
//  flush_i             redirect: discard all buffered halfwords
//  fetch_valid_i/_ready_o, fetch_data_i, fetch_pc_i   fetch word input
//  inst_valid_o/inst_ready_i, inst_o, inst_pc_o        instruction output
//  inst_compressed_o   inst_o is a 16-bit instruction (zero-extended)
//  inst_misaligned_o   instruction-address-misaligned tag
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter int VADDR = 39
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             fetch_valid_i,
    output logic             fetch_ready_o,
    input  logic [31:0]      fetch_data_i,
    input  logic [VADDR-1:0] fetch_pc_i,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [31:0]      inst_o,
    output logic [VADDR-1:0] inst_pc_o,
    output logic             inst_compressed_o,
    output logic             inst_misaligned_o
);

    halfword_t        q_head_lo;
    halfword_t        q_head_hi;
    count_t           q_count;
    logic [1:0]       push_cnt;
    halfword_t        push_lo;
    halfword_t        push_hi;
    logic [1:0]       pop_cnt;
    logic             fetch_accept;
    logic             inst_fire;
    logic [VADDR-1:0] head_pc_reg;
    logic [VADDR-1:0] head_pc_next;

    assign fetch_accept = fetch_valid_i & fetch_ready_o;
    assign inst_fire    = inst_valid_o & inst_ready_i & ~flush_i;

    fetch_aligner_halfword_queue u_queue (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .flush    (flush_i),
        .push_cnt (push_cnt),
        .push_lo  (push_lo),
        .push_hi  (push_hi),
        .pop_cnt  (pop_cnt),
        .head_lo  (q_head_lo),
        .head_hi  (q_head_hi),
        .count    (q_count)
    );

`ifdef ALIGNER_RVC_EN

    logic head_full;
    assign head_full = is_full_inst(q_head_lo);

    // Two free slots are always enough for a whole fetch word, independent
    // of whether decode pops this cycle.
    assign fetch_ready_o = (q_count <= count_t'(2)) & ~flush_i;

    always_comb begin
        push_cnt = 2'd0;
        push_lo  = fetch_data_i[15:0];
        push_hi  = fetch_data_i[31:16];
        if (fetch_accept) begin
            if (fetch_pc_i[1]) begin
                // Lower halfword lies before the wanted PC: keep upper only.
                push_cnt = 2'd1;
                push_lo  = fetch_data_i[31:16];
            end else begin
                push_cnt = 2'd2;
            end
        end
    end

    always_comb begin
        inst_valid_o      = head_full ? (q_count >= count_t'(2)) : (q_count >= count_t'(1));
        inst_o            = '0;
        inst_compressed_o = 1'b0;
        inst_misaligned_o = 1'b0;
        inst_pc_o         = head_pc_reg;
        if (inst_valid_o) begin
            inst_o            = head_full ? {q_head_hi, q_head_lo} : {16'h0000, q_head_lo};
            inst_compressed_o = ~head_full;
        end
        pop_cnt = inst_fire ? (head_full ? 2'd2 : 2'd1) : 2'd0;
    end

`else

    logic             mis_pending_reg;
    logic [VADDR-1:0] mis_pc_reg;
    logic             q_valid;

    assign q_valid = (q_count >= count_t'(2));

    // While a misaligned tag waits, further fetches are held back so the trap
    // stays in program order behind any words already queued.
    assign fetch_ready_o = (q_count <= count_t'(2)) & ~flush_i & ~mis_pending_reg;

    always_comb begin
        push_cnt = (fetch_accept && !fetch_pc_i[1]) ? 2'd2 : 2'd0;
        push_lo  = fetch_data_i[15:0];
        push_hi  = fetch_data_i[31:16];
    end

    always_comb begin
        inst_valid_o      = q_valid | mis_pending_reg;
        inst_o            = '0;
        inst_compressed_o = 1'b0;
        inst_misaligned_o = 1'b0;
        inst_pc_o         = head_pc_reg;
        if (q_valid) begin
            inst_o = {q_head_hi, q_head_lo};
        end else if (mis_pending_reg) begin
            inst_misaligned_o = 1'b1;
            inst_pc_o         = mis_pc_reg;
        end
        pop_cnt = (inst_fire && q_valid) ? 2'd2 : 2'd0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_pending_reg <= 1'b0;
            mis_pc_reg      <= '0;
        end else if (flush_i) begin
            mis_pending_reg <= 1'b0;
        end else if (fetch_accept && fetch_pc_i[1]) begin
            mis_pending_reg <= 1'b1;
            mis_pc_reg      <= fetch_pc_i;
        end else if (inst_fire && !q_valid) begin
            mis_pending_reg <= 1'b0;
        end
    end

`endif

    // head_pc tracks the PC of queue entry 0. It is reloaded from the fetch PC
    // whenever the pushed halfwords become the new head (queue empty after
    // this cycle's pop); otherwise it advances by the popped size.
    always_comb begin
        head_pc_next = head_pc_reg;
        if (!flush_i) begin
            if ((push_cnt != 2'd0) && (q_count == count_t'(pop_cnt))) begin
                head_pc_next = fetch_pc_i;
            end else if (pop_cnt != 2'd0) begin
                head_pc_next = head_pc_reg + (VADDR'(pop_cnt) << 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_pc_reg <= '0;
        end else begin
            head_pc_reg <= head_pc_next;
        end
    end

endmodule
